// File: rtl/alu_ctrl_stage_pkg.sv
// Opcode fields, ALU function codes and FSM state encoding for the ALU-control decode stage.
// Immediate opcodes reuse the REGISTER-class op_lo code points.
package alu_ctrl_stage_pkg;

    localparam logic [3:0] OP_REGISTER = 4'b0000;
    localparam logic [3:0] OP_ANDI     = 4'b0001;
    localparam logic [3:0] OP_ORI      = 4'b0010;
    localparam logic [3:0] OP_XORI     = 4'b0011;
    localparam logic [3:0] OP_SPECIAL  = 4'b0100;
    localparam logic [3:0] OP_ADDI     = 4'b0101;
    localparam logic [3:0] OP_ADDUI    = 4'b0110;
    localparam logic [3:0] OP_ADDCI    = 4'b0111;
    localparam logic [3:0] OP_SUBI     = 4'b1001;
    localparam logic [3:0] OP_SUBCI    = 4'b1010;
    localparam logic [3:0] OP_CMPI     = 4'b1011;
    localparam logic [3:0] OP_MULI     = 4'b1110;

    localparam logic [3:0] FN_AND = 4'b0001;
    localparam logic [3:0] FN_OR  = 4'b0010;
    localparam logic [3:0] FN_XOR = 4'b0011;
    localparam logic [3:0] FN_ADD = 4'b0101;
    localparam logic [3:0] FN_SUB = 4'b1001;
    localparam logic [3:0] FN_CMP = 4'b1011;
    localparam logic [3:0] FN_MUL = 4'b1110;

    localparam logic [3:0] ALU_OP_AND  = 4'b0000;
    localparam logic [3:0] ALU_OP_OR   = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD  = 4'b0010;
    localparam logic [3:0] ALU_OP_CMP  = 4'b0011;
    localparam logic [3:0] ALU_OP_NOP  = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OP_ADDC = 4'b0110;
    localparam logic [3:0] ALU_OP_MUL  = 4'b0111;
    localparam logic [3:0] ALU_OP_SUB  = 4'b1010;
    localparam logic [3:0] ALU_OP_SUBC = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/alu_ctrl_stage_decode.sv
// Purpose: combinational {op_hi,op_lo} -> {alu_op,flag_we,illegal,is_mul}; carry ops under ALU_CARRY_OPS_EN.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; consumer registers the result on accept.
module alu_op_decode
    import alu_ctrl_stage_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int AOPW = 4
) (
    input  logic [OPW-1:0]  op_hi,
    input  logic [OPW-1:0]  op_lo,
    output logic [AOPW-1:0] alu_op,
    output logic            flag_we,
    output logic            illegal,
    output logic            is_mul
);

    logic [3:0] hi4;
    logic [3:0] lo4;
    logic [3:0] op4;
    logic       hi_ext;
    logic       lo_ext;
    logic       base_illegal;

    assign hi4 = op_hi[3:0];
    assign lo4 = op_lo[3:0];

    // Extra opcode bits on wide builds must be zero; op_lo only matters for REGISTER class.
    generate
        if (OPW > 4) begin : g_wide
            assign hi_ext = |op_hi[OPW-1:4];
            assign lo_ext = |op_lo[OPW-1:4];
        end else begin : g_narrow
            assign hi_ext = 1'b0;
            assign lo_ext = 1'b0;
        end
    endgenerate

    always_comb begin
        op4          = ALU_OP_NOP;
        flag_we      = 1'b0;
        base_illegal = 1'b0;
        is_mul       = 1'b0;
        case (hi4)
            OP_REGISTER: begin
                case (lo4)
                    FN_AND: op4 = ALU_OP_AND;
                    FN_OR:  op4 = ALU_OP_OR;
                    FN_XOR: op4 = ALU_OP_XOR;
                    FN_ADD: begin op4 = ALU_OP_ADD; flag_we = 1'b1; end
                    FN_SUB: begin op4 = ALU_OP_SUB; flag_we = 1'b1; end
                    FN_CMP: begin op4 = ALU_OP_CMP; flag_we = 1'b1; end
                    FN_MUL: begin op4 = ALU_OP_MUL; is_mul  = 1'b1; end
                    default: base_illegal = 1'b1;
                endcase
                if (lo_ext) base_illegal = 1'b1;
            end
            OP_ANDI:    op4 = ALU_OP_AND;
            OP_ORI:     op4 = ALU_OP_OR;
            OP_XORI:    op4 = ALU_OP_XOR;
            OP_ADDI:    begin op4 = ALU_OP_ADD; flag_we = 1'b1; end
            OP_SUBI:    begin op4 = ALU_OP_SUB; flag_we = 1'b1; end
            OP_CMPI:    begin op4 = ALU_OP_CMP; flag_we = 1'b1; end
            OP_MULI:    begin op4 = ALU_OP_MUL; is_mul  = 1'b1; end
            OP_SPECIAL: op4 = ALU_OP_NOP;
`ifdef ALU_CARRY_OPS_EN
            OP_ADDUI:   op4 = ALU_OP_ADDC;
            OP_ADDCI:   begin op4 = ALU_OP_ADDC; flag_we = 1'b1; end
            OP_SUBCI:   begin op4 = ALU_OP_SUBC; flag_we = 1'b1; end
`endif
            default:    base_illegal = 1'b1;
        endcase
        if (base_illegal || hi_ext) begin
            op4     = ALU_OP_NOP;
            flag_we = 1'b0;
            is_mul  = 1'b0;
        end
    end

    assign illegal = base_illegal | hi_ext;
    assign alu_op  = AOPW'(op4);

endmodule

// File: rtl/alu_ctrl_stage.sv
// Purpose: registered ALU-control decode stage with single-entry output buffer (carry ops: ALU_CARRY_OPS_EN).
// Latency: 1 cycle accept->out_valid; MUL/MULI take MUL_LAT cycles.
// Backpressure: holds entry until out_ready; in_ready low during multiply wait; flush squashes.
module alu_ctrl_stage
    import alu_ctrl_stage_pkg::*;
#(
    parameter int OPW     = 4,
    parameter int AOPW    = 4,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  op_hi,
    input  logic [OPW-1:0]  op_lo,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AOPW-1:0] alu_op,
    output logic            flag_we,
    output logic            illegal,
    output logic            mul_busy
);

    localparam logic [3:0] MUL_RELOAD = 4'(MUL_LAT - 1);

    state_t          state;
    logic [3:0]      cnt;
    logic            accept;
    logic [AOPW-1:0] dec_op;
    logic            dec_fw;
    logic            dec_ill;
    logic            dec_mul;

    alu_op_decode #(.OPW(OPW), .AOPW(AOPW)) u_decode (
        .op_hi   (op_hi),
        .op_lo   (op_lo),
        .alu_op  (dec_op),
        .flag_we (dec_fw),
        .illegal (dec_ill),
        .is_mul  (dec_mul)
    );

    assign in_ready = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            out_valid <= 1'b0;
            mul_busy  <= 1'b0;
            alu_op    <= AOPW'(ALU_OP_NOP);
            flag_we   <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            // Decode registers keep their last value; only the entry is dropped.
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            out_valid <= 1'b0;
            mul_busy  <= 1'b0;
        end else if (accept) begin
            alu_op  <= dec_op;
            flag_we <= dec_fw;
            illegal <= dec_ill;
            if (dec_mul && (MUL_LAT > 1)) begin
                state     <= ST_WAIT;
                cnt       <= MUL_RELOAD;
                out_valid <= 1'b0;
                mul_busy  <= 1'b1;
            end else begin
                state     <= ST_HOLD;
                out_valid <= 1'b1;
                mul_busy  <= 1'b0;
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        mul_busy  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
